// File: rtl/solution_serializer_if.sv
// solution_serializer_if: solver / uart_tx facing bundle of the solution serializer.
// The solver and uart_tx side uses the master modport; the serializer uses slave.
interface solution_serializer_if #(
  parameter int MAX_ROWS = 11,
  parameter int MAX_COLS = 11
);
  localparam int RW = $clog2(MAX_ROWS + 1);
  localparam int CW = $clog2(MAX_COLS + 1);

  logic                         valid_in;
  logic [MAX_ROWS*MAX_COLS-1:0] solution;
  logic [RW-1:0]                m;
  logic [CW-1:0]                n;
  logic                         transmit_done;
  logic                         send;
  logic [7:0]                   byte_out;
  logic                         busy;
  logic                         done;

  modport master (
    output valid_in, solution, m, n, transmit_done,
    input  send, byte_out, busy, done
  );

  modport slave (
    input  valid_in, solution, m, n, transmit_done,
    output send, byte_out, busy, done
  );
endinterface

// File: rtl/solution_serializer.sv
// solution_serializer: latches an m x n solved board and streams it to uart_tx as
// header bytes (m, n) followed by each row packed LSB-first into ceil(n/8) bytes.
// Optional feature: define SERIALIZER_CHECKSUM_EN to append an XOR checksum byte.
module solution_serializer #(
  parameter int MAX_ROWS = 11,
  parameter int MAX_COLS = 11
) (
  input logic clk,
  input logic rst_n,
  solution_serializer_if.slave bus
);
  localparam int SW = MAX_ROWS * MAX_COLS;
  localparam logic [7:0] MAXR8 = 8'(MAX_ROWS);
  localparam logic [7:0] MAXC8 = 8'(MAX_COLS);

`ifdef SERIALIZER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_CKSUM, S_FIN} state_t;
  typedef enum logic [1:0] {P_M, P_N, P_ROW, P_CK} phase_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_FIN} state_t;
  typedef enum logic [1:0] {P_M, P_N, P_ROW} phase_t;
`endif

  state_t          state_q, state_d;
  phase_t          phase_q, phase_d;
  logic [SW-1:0]   sol_q, sol_d;
  logic [7:0]      m_q, m_d, n_q, n_d, bpr_q, bpr_d;
  logic [7:0]      row_q, row_d, kb_q, kb_d;
  logic            send_q, send_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]      byte_q, byte_d;
  logic [7:0]      next_byte_s;
  logic            last_s;
`ifdef SERIALIZER_CHECKSUM_EN
  logic [7:0]      cks_q, cks_d;
`endif

  // Byte kb of board row 'row': cells 8*kb..8*kb+7, columns at or beyond ncols read as 0.
  function automatic logic [7:0] row_byte(input logic [SW-1:0] sol, input logic [7:0] row,
                                          input logic [7:0] kb, input logic [7:0] ncols);
    logic [31:0] c0;
    logic [31:0] nc;
    logic [31:0] base;
    logic [7:0]  low8;
    logic [7:0]  mask;
    c0   = 32'(kb) << 3;
    nc   = 32'(ncols);
    base = 32'(row) * 32'(MAX_COLS) + c0;
    low8 = 8'({8'h00, sol} >> base);
    if (nc >= c0 + 32'd8) begin
      mask = 8'hFF;
    end else if (nc > c0) begin
      mask = 8'((9'h001 << (nc - c0)) - 9'h001);
    end else begin
      mask = 8'h00;
    end
    return low8 & mask;
  endfunction

  // Next-state, index advance and output-register next values.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    sol_d       = sol_q;
    m_d         = m_q;
    n_d         = n_q;
    bpr_d       = bpr_q;
    row_d       = row_q;
    kb_d        = kb_q;
    last_s      = 1'b0;
    next_byte_s = 8'h00;
`ifdef SERIALIZER_CHECKSUM_EN
    cks_d       = cks_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.valid_in) begin
          sol_d   = bus.solution;
          m_d     = (8'(bus.m) > MAXR8) ? MAXR8 : 8'(bus.m);
          n_d     = (8'(bus.n) > MAXC8) ? MAXC8 : 8'(bus.n);
          state_d = S_LOAD;
`ifdef SERIALIZER_CHECKSUM_EN
          cks_d   = 8'h00;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        bpr_d   = 8'((9'(n_q) + 9'd7) >> 3);
        phase_d = P_M;
        row_d   = 8'd0;
        kb_d    = 8'd0;
        state_d = S_SEND;
      end
      S_SEND: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.transmit_done) begin
          case (phase_q)
            P_M: begin
              phase_d = P_N;
              state_d = S_SEND;
            end
            P_N: begin
              if ((m_q == 8'd0) || (n_q == 8'd0)) begin
                last_s = 1'b1;
              end else begin
                phase_d = P_ROW;
                state_d = S_SEND;
              end
            end
            P_ROW: begin
              if ((kb_q + 8'd1) < bpr_q) begin
                kb_d    = kb_q + 8'd1;
                state_d = S_SEND;
              end else if ((row_q + 8'd1) < m_q) begin
                kb_d    = 8'd0;
                row_d   = row_q + 8'd1;
                state_d = S_SEND;
              end else begin
                last_s = 1'b1;
              end
            end
            default: state_d = S_FIN;
          endcase
        end else begin
          state_d = S_WAIT;
        end
      end
`ifdef SERIALIZER_CHECKSUM_EN
      S_CKSUM: state_d = S_WAIT;
`endif
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Stream exhausted: either the checksum byte follows or the frame ends.
    if (last_s) begin
`ifdef SERIALIZER_CHECKSUM_EN
      phase_d = P_CK;
      state_d = S_CKSUM;
`else
      state_d = S_FIN;
`endif
    end else begin
      phase_d = phase_d;
    end

    case (phase_d)
      P_M:     next_byte_s = m_q;
      P_N:     next_byte_s = n_q;
      P_ROW:   next_byte_s = row_byte(sol_q, row_d, kb_d, n_q);
`ifdef SERIALIZER_CHECKSUM_EN
      P_CK:    next_byte_s = cks_q;
`endif
      default: next_byte_s = 8'h00;
    endcase

`ifdef SERIALIZER_CHECKSUM_EN
    send_d = (state_d == S_SEND) || (state_d == S_CKSUM);
    if (state_d == S_SEND) begin
      cks_d = cks_q ^ next_byte_s;
    end else begin
      cks_d = cks_d;
    end
`else
    send_d = (state_d == S_SEND);
`endif
    byte_d = send_d ? next_byte_s : byte_q;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // State, latched board, indices and registered outputs; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= P_M;
      sol_q   <= '0;
      m_q     <= 8'h00;
      n_q     <= 8'h00;
      bpr_q   <= 8'h00;
      row_q   <= 8'h00;
      kb_q    <= 8'h00;
      send_q  <= 1'b0;
      byte_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIALIZER_CHECKSUM_EN
      cks_q   <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      sol_q   <= sol_d;
      m_q     <= m_d;
      n_q     <= n_d;
      bpr_q   <= bpr_d;
      row_q   <= row_d;
      kb_q    <= kb_d;
      send_q  <= send_d;
      byte_q  <= byte_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIALIZER_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  assign bus.send     = send_q;
  assign bus.byte_out = byte_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_solution_serializer.sv
// tb_solution_serializer: randomized bench for solution_serializer against a
// byte-list reference model; acts as solver (valid_in) and uart_tx (transmit_done).
module tb_solution_serializer;
  localparam int MR = 11;
  localparam int MC = 11;
  localparam int SW = MR * MC;
  localparam int RW = $clog2(MR + 1);
  localparam int CW = $clog2(MC + 1);
`ifdef SERIALIZER_CHECKSUM_EN
  localparam int NB_FULL = 25;
`else
  localparam int NB_FULL = 24;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cap_q[$];
  logic [7:0] ref1_q[$];
  logic [SW-1:0] ones;
  logic [SW-1:0] s;
  logic [SW-1:0] msk;

  solution_serializer_if #(.MAX_ROWS(MR), .MAX_COLS(MC)) bus ();
  solution_serializer #(.MAX_ROWS(MR), .MAX_COLS(MC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [SW-1:0] rand_sol();
    logic [SW-1:0] r;
    r = '0;
    for (int i = 0; i < SW; i++) r = {r[SW-2:0], 1'($urandom)};
    return r;
  endfunction

  // Reference byte list straight from the frame rules: header, packed rows, optional XOR.
  task automatic build_exp(input int fm, input int fn, input logic [SW-1:0] sol);
    int mm, nn, bpr;
    logic [7:0] b;
    logic [7:0] x;
    logic [SW-1:0] t;
    mm = (fm > MR) ? MR : fm;
    nn = (fn > MC) ? MC : fn;
    bpr = (nn + 7) / 8;
    exp_q = {};
    exp_q.push_back(8'(mm));
    exp_q.push_back(8'(nn));
    if (mm > 0 && nn > 0) begin
      for (int r = 0; r < mm; r++) begin
        for (int k = 0; k < bpr; k++) begin
          b = 8'h00;
          for (int j = 0; j < 8; j++) begin
            t = sol >> (r * MC + 8 * k + j);
            if ((8 * k + j) < nn && t[0]) b = b | (8'h01 << j);
          end
          exp_q.push_back(b);
        end
      end
    end
`ifdef SERIALIZER_CHECKSUM_EN
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
    exp_q.push_back(x);
`else
    x = 8'h00;
`endif
  endtask

  // One frame: pulse valid_in, serve every byte as uart_tx, check timing and data.
  task automatic run_frame(input int fm, input int fn, input logic [SW-1:0] fsol,
                           input int max_delay, input bit interfere, input int abort_at);
    int nb, d;
    logic [7:0] held;
    bit last;
    build_exp(fm, fn, fsol);
    nb = exp_q.size();
    cap_q = {};
    bus.valid_in = 1'b1;
    bus.m = RW'(fm);
    bus.n = CW'(fn);
    bus.solution = fsol;
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.m = RW'($urandom);
    bus.n = CW'($urandom);
    bus.solution = rand_sol();
    chk_eq("busy_accept", 32'(bus.busy), 32'd1);
    chk_eq("send_load", 32'(bus.send), 32'd0);
    @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      chk_eq($sformatf("send_b%0d", i), 32'(bus.send), 32'd1);
      chk_eq($sformatf("byte_b%0d", i), 32'(bus.byte_out), 32'(exp_q[i]));
      chk_eq("done_early", 32'(bus.done), 32'd0);
      held = bus.byte_out;
      cap_q.push_back(held);
      if (interfere && $urandom_range(0, 3) == 0) bus.transmit_done = 1'b1;
      @(negedge clk);
      bus.transmit_done = 1'b0;
      chk_eq("send_once", 32'(bus.send), 32'd0);
      chk_eq("byte_hold", 32'(bus.byte_out), 32'(held));
      if (i == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_eq("rst_send", 32'(bus.send), 32'd0);
        chk_eq("rst_byte", 32'(bus.byte_out), 32'd0);
        chk_eq("rst_busy", 32'(bus.busy), 32'd0);
        chk_eq("rst_done", 32'(bus.done), 32'd0);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk_eq("abort_done", 32'(bus.done), 32'd0);
          chk_eq("abort_send", 32'(bus.send), 32'd0);
        end
        return;
      end
      d = $urandom_range(0, max_delay);
      for (int k = 0; k < d; k++) begin
        if (interfere && k == d / 2) begin
          bus.valid_in = 1'b1;
          bus.m = RW'($urandom);
          bus.n = CW'($urandom);
          bus.solution = rand_sol();
        end
        @(negedge clk);
        bus.valid_in = 1'b0;
        chk_eq("send_wait", 32'(bus.send), 32'd0);
        chk_eq("byte_wait", 32'(bus.byte_out), 32'(held));
      end
      last = (i == nb - 1);
      bus.transmit_done = 1'b1;
      if (interfere && last) bus.valid_in = 1'b1;
      @(negedge clk);
      bus.transmit_done = 1'b0;
      bus.valid_in = 1'b0;
    end
    chk_eq("done_pulse", 32'(bus.done), 32'd1);
    chk_eq("send_fin", 32'(bus.send), 32'd0);
    chk_eq("busy_fin", 32'(bus.busy), 32'd1);
    if (interfere) bus.valid_in = 1'b1;
    @(negedge clk);
    bus.valid_in = 1'b0;
    chk_eq("busy_idle", 32'(bus.busy), 32'd0);
    chk_eq("done_once", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk_eq("no_restart_busy", 32'(bus.busy), 32'd0);
    chk_eq("no_restart_send", 32'(bus.send), 32'd0);
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.solution = '0;
    bus.m = '0;
    bus.n = '0;
    bus.transmit_done = 1'b0;
    ones = '1;
    repeat (2) @(negedge clk);
    chk_eq("reset_send", 32'(bus.send), 32'd0);
    chk_eq("reset_byte", 32'(bus.byte_out), 32'd0);
    chk_eq("reset_busy", 32'(bus.busy), 32'd0);
    chk_eq("reset_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full 11x11 board of ones.
    run_frame(11, 11, ones, 0, 1'b0, -1);
    chk_eq("len_full", 32'(cap_q.size()), 32'(NB_FULL));
    ref1_q = cap_q;
`ifdef SERIALIZER_CHECKSUM_EN
    if (cap_q.size() == 25) chk_eq("cksum_full", 32'(cap_q[24]), 32'hF8);
`endif

    // 3x5 with only cell (1,2) set inside the board; outside cells random.
    msk = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) msk = msk | ({{(SW-1){1'b0}}, 1'b1} << (r * MC + c));
    s = (rand_sol() & ~msk) | ({{(SW-1){1'b0}}, 1'b1} << (1 * MC + 2));
    run_frame(3, 5, s, 2, 1'b0, -1);
    if (cap_q.size() >= 5) begin
      chk_eq("t2_b0", 32'(cap_q[0]), 32'h03);
      chk_eq("t2_b1", 32'(cap_q[1]), 32'h05);
      chk_eq("t2_b2", 32'(cap_q[2]), 32'h00);
      chk_eq("t2_b3", 32'(cap_q[3]), 32'h04);
      chk_eq("t2_b4", 32'(cap_q[4]), 32'h00);
    end else begin
      chk_eq("t2_len", 32'(cap_q.size()), 32'd5);
    end

    // Slow uart, spurious done and second valid_in mid-stream: same stream as before.
    run_frame(11, 11, ones, 100, 1'b1, -1);
    chk_eq("slow_len", 32'(cap_q.size()), 32'(ref1_q.size()));
    for (int i = 0; i < cap_q.size() && i < ref1_q.size(); i++)
      chk_eq($sformatf("slow_same%0d", i), 32'(cap_q[i]), 32'(ref1_q[i]));

    // Header-only frame and two-byte-per-row frame.
    run_frame(0, 7, rand_sol(), 1, 1'b0, -1);
`ifdef SERIALIZER_CHECKSUM_EN
    chk_eq("len_m0", 32'(cap_q.size()), 32'd3);
`else
    chk_eq("len_m0", 32'(cap_q.size()), 32'd2);
`endif
    run_frame(11, 9, rand_sol(), 1, 1'b0, -1);
    for (int r = 0; r < 11; r++)
      if (cap_q.size() > 3 + 2 * r) chk_eq($sformatf("n9_pad_r%0d", r), 32'(cap_q[3 + 2 * r] & 8'hFE), 32'd0);

    // Reset during the fifth byte's wait, then a fresh frame.
    run_frame(11, 11, ones, 3, 1'b0, 4);
    run_frame(11, 11, ones, 0, 1'b0, -1);
    chk_eq("restart_hdr", 32'(cap_q[0]), 32'h0B);

    // Random frames, sizes include values above the maximum (clamped).
    for (int f = 0; f < 20; f++)
      run_frame(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), rand_sol(), 3, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
